vec_popcnt_stream: RTL and testbench
====================================

# vec_popcnt_stream

Parametrised successor to the fingerprint pre-stage popcount unit. Accepts a fingerprint vector as a stream of `BUS_WIDTH` sub-vectors and forwards each sub-vector unchanged except for padding. Accumulates the vector's population count and presents it, with a per-vector ID, alongside the last sub-vector. Over the original pre-stage it adds:
- padding masking for `VECTOR_WIDTH` not a multiple of `BUS_WIDTH`;
- a two-stage granule adder pipeline;
- full valid/ready backpressure;
- a wrapping vector ID.

## Interface
Parameters:
- `VECTOR_WIDTH`, 920, fingerprint bits per vector (≥1).
- `BUS_WIDTH`, 128, sub-vector width per beat.
- `GRANULE_WIDTH`, 6, bits per first-level popcount granule (LUT-sized).
- `ID_WIDTH`, 16, vector ID counter width.
- Derived, not overridable:
  - `SUB_VECTOR_NO = ceil(VECTOR_WIDTH/BUS_WIDTH)`.
  - `LAST_BITS = VECTOR_WIDTH - (SUB_VECTOR_NO-1)*BUS_WIDTH`.
  - `CNT_WIDTH = clog2(VECTOR_WIDTH+1)`.
  - `GRANULE_NO = ceil(BUS_WIDTH/GRANULE_WIDTH)`.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `i_Vector` in `BUS_WIDTH`: input sub-vector.
- `i_Valid` in 1: input beat valid.
- `o_Ready` out 1: block accepts a beat this cycle.
- `o_SubVector` out `BUS_WIDTH`: forwarded sub-vector, padding zeroed.
- `o_Valid` out 1: output beat valid.
- `i_Ready` in 1: downstream accepts the output beat.
- `o_Cnt` out `CNT_WIDTH`: popcount of the most recently completed vector.
- `o_CntNew` out 1: current output beat is the last sub-vector of a vector.
- `o_VecId` out `ID_WIDTH`: ID of the vector the current output beat belongs to.
- `o_PadErr` out 1: present only with `VEC_POPCNT_PAD_CHECK_EN`.

## Operation
- Input transfer when `i_Valid && o_Ready`. Output transfer when `o_Valid && i_Ready`.
- Beat counter `beat_idx` counts 0..`SUB_VECTOR_NO`-1 on input transfers. It wraps to 0 after the last beat and increments `vec_id`, which wraps modulo 2^`ID_WIDTH`.
- Last beat (`beat_idx == SUB_VECTOR_NO-1`): bits [`BUS_WIDTH`-1:`LAST_BITS`] are forced to 0 both in the forwarded data and in the count. When `LAST_BITS == BUS_WIDTH`, no masking is applied.
- Stage 1 (on input transfer) registers:
  - the masked beat;
  - per-granule popcounts (the final granule is partial if `BUS_WIDTH % GRANULE_WIDTH != 0`);
  - the last flag and the ID.
- Stage 2 sums the granule counts into the beat count (width `clog2(BUS_WIDTH+1)`) and adds it to the accumulator (`CNT_WIDTH`, zero-extended, cannot overflow).
  - On a last beat: `o_Cnt` ← accumulator + beat count, the accumulator clears to 0, and `o_CntNew`=1 for that output beat.
  - On other beats: `o_CntNew`=0 and `o_Cnt` holds its previous value.
- `SUB_VECTOR_NO == 1`: every beat is a last beat and `o_Cnt` is that beat's count.
- Pipeline enable `en = !s2_valid || i_Ready`; `o_Ready = en` (combinational from `i_Ready`). While `en`=0 both stages hold, and `o_SubVector`/`o_Cnt`/`o_CntNew`/`o_VecId` remain stable while `o_Valid && !i_Ready`.
- Bubbles (`i_Valid`=0 with `en`=1) propagate as `o_Valid`=0 and do not touch the accumulator or counters.

## Timing
- Latency: accepted beat at edge N appears on the outputs after edge N+2 (2 cycles); 1 beat/cycle sustained when `i_Ready`=1.
- Reset:
  - outputs `o_Valid`, `o_CntNew`, `o_Cnt`, `o_SubVector`, `o_VecId`, `o_PadErr` all 0;
  - internal `beat_idx`=0, accumulator=0, `vec_id`=0, stage valids=0;
  - `o_Ready` is 1 in the cycle after reset deasserts.
- Reset mid-vector discards all partial state; the next accepted beat is beat 0 of ID 0.
- Output valid and input valid in the same cycle with `i_Ready`=1: the pipeline shifts and both transfers complete.
- `i_Ready` deasserted while `o_CntNew`=1: the last beat and `o_Cnt` hold until accepted, and no new vector's count overwrites them.

## Configuration
- `VEC_POPCNT_PAD_CHECK_EN` defined:
  - the `o_PadErr` port exists;
  - it becomes 1 sticky on the cycle after a last-beat input transfer whose pre-mask padding bits are non-zero;
  - it clears only on `rst`;
  - data is still masked.
- Macro undefined: the port and logic are absent; padding is silently masked.

## Structure
- Shared package `fp_accel_pkg`: `clog2`-based derived-width functions, `SUB_VECTOR_NO`/`LAST_BITS`/`CNT_WIDTH` computation functions, and the default `VECTOR_WIDTH`/`BUS_WIDTH`/`GRANULE_WIDTH` constants used across the accelerator.
- One sub-module, `popcnt_granule_tree`: parametrised by `BUS_WIDTH` and `GRANULE_WIDTH`, it computes per-granule counts and their sum for one beat. The stage-1 registers sit between its granule and sum levels, and the sub-module exposes an enable input.

## Test plan
Defaults: `VECTOR_WIDTH`=920, `BUS_WIDTH`=128, so `SUB_VECTOR_NO`=8 and `LAST_BITS`=24.
- All-ones vector, `i_Ready`=1 -> 8 output beats; beat 8's `o_SubVector`=0x…00FFFFFF (upper 104 bits 0); `o_Cnt`=920 with `o_CntNew`=1 only on beat 8; `o_VecId`=0.
- Two back-to-back vectors (all-zeros, then 0x1 in every beat) -> `o_Cnt`=0 with ID 0, then 8 with ID 1; first output exactly 2 cycles after the first accepted beat.
- Random vectors with `i_Ready` toggling randomly 1–10 cycles on / 1–5 off -> no beat lost or duplicated; `o_Cnt` matches the reference model; outputs stable while stalled.
- Reset asserted after beat 3 of a vector, then a full all-ones vector -> `o_Cnt`=920, `o_VecId`=0, no stale partial sum.
- With `VEC_POPCNT_PAD_CHECK_EN`, last beat has bit 127 set -> `o_PadErr`=1 next cycle and stays 1; `o_Cnt` excludes bit 127.
- ID wrap (`ID_WIDTH`=2), 5 vectors -> `o_VecId` sequence 0,1,2,3,0.

Source files
------------

// File: rtl/fp_accel_pkg.sv
// -----------------------------------------------------------------------------
// fp_accel_pkg
// Shared constants and derived-width helpers for the fingerprint accelerator.
//   DEF_*                  : default geometry used across the accelerator
//   clog2                  : ceil(log2(v)), 0 for v <= 1
//   calc_sub_vector_no     : beats per vector, ceil(VECTOR_WIDTH/BUS_WIDTH)
//   calc_last_bits         : meaningful bits in the final beat of a vector
//   calc_cnt_width         : width able to hold a full-vector popcount
//   calc_granule_no        : first-level popcount granules per beat
//   calc_beat_cnt_width    : width able to hold a single-beat popcount
//   calc_idx_width         : beat index width (at least 1 bit)
// -----------------------------------------------------------------------------
package fp_accel_pkg;

  localparam int DEF_VECTOR_WIDTH  = 920;
  localparam int DEF_BUS_WIDTH     = 128;
  localparam int DEF_GRANULE_WIDTH = 6;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int calc_sub_vector_no(input int vector_width, input int bus_width);
    return (vector_width + bus_width - 1) / bus_width;
  endfunction

  function automatic int calc_last_bits(input int vector_width, input int bus_width);
    return vector_width - (calc_sub_vector_no(vector_width, bus_width) - 1) * bus_width;
  endfunction

  function automatic int calc_cnt_width(input int vector_width);
    return clog2(vector_width + 1);
  endfunction

  function automatic int calc_granule_no(input int bus_width, input int granule_width);
    return (bus_width + granule_width - 1) / granule_width;
  endfunction

  function automatic int calc_beat_cnt_width(input int bus_width);
    return clog2(bus_width + 1);
  endfunction

  function automatic int calc_idx_width(input int sub_vector_no);
    return (sub_vector_no > 1) ? clog2(sub_vector_no) : 1;
  endfunction

endpackage

// File: rtl/popcnt_granule_tree.sv
// -----------------------------------------------------------------------------
// popcnt_granule_tree
// Two-level popcount of one beat. Level 1 counts each GRANULE_WIDTH-bit slice
// (LUT-sized) and registers the granule counts; level 2 is a combinational sum
// of the registered counts, so the register sits between the two levels.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (clears granule registers)
//   en         : pipeline enable, granule registers load when high
//   i_Vector   : beat to count (already masked by the caller)
//   o_BeatCnt  : popcount of the beat captured at the last enabled edge
// -----------------------------------------------------------------------------
module popcnt_granule_tree
  import fp_accel_pkg::*;
#(
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int GRANULE_WIDTH = DEF_GRANULE_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [BUS_WIDTH-1:0]                      i_Vector,
  output logic [calc_beat_cnt_width(BUS_WIDTH)-1:0] o_BeatCnt
);

  localparam int GRANULE_NO = calc_granule_no(BUS_WIDTH, GRANULE_WIDTH);
  localparam int GCW        = clog2(GRANULE_WIDTH + 1);
  localparam int BCW        = calc_beat_cnt_width(BUS_WIDTH);
  localparam int PAD_WIDTH  = GRANULE_NO * GRANULE_WIDTH;

  function automatic logic [GCW-1:0] gran_pop(input logic [GRANULE_WIDTH-1:0] g);
    logic [GCW-1:0] r;
    r = '0;
    for (int i = 0; i < GRANULE_WIDTH; i++) begin
      r = r + GCW'(g[i]);
    end
    return r;
  endfunction

  // Zero-extend so a partial final granule simply counts its missing bits as 0.
  logic [PAD_WIDTH-1:0] vec_pad;
  assign vec_pad = PAD_WIDTH'(i_Vector);

  logic [GRANULE_NO-1:0][GCW-1:0] gran_cnt_next;
  logic [GRANULE_NO-1:0][GCW-1:0] gran_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < GRANULE_NO; gi++) begin : g_gran
      assign gran_cnt_next[gi] = gran_pop(vec_pad[gi*GRANULE_WIDTH +: GRANULE_WIDTH]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      gran_cnt_reg <= '0;
    end else if (en) begin
      gran_cnt_reg <= gran_cnt_next;
    end
  end

  logic [BCW-1:0] beat_sum;
  always_comb begin
    beat_sum = '0;
    for (int g = 0; g < GRANULE_NO; g++) begin
      beat_sum = beat_sum + BCW'(gran_cnt_reg[g]);
    end
  end

  assign o_BeatCnt = beat_sum;

endmodule

// File: rtl/vec_popcnt_stream.sv
// -----------------------------------------------------------------------------
// vec_popcnt_stream
// Streams a fingerprint vector as BUS_WIDTH-bit beats, forwards each beat with
// the padding of the final beat zeroed, and reports the vector popcount plus a
// wrapping vector ID alongside the final beat. Two register stages, full
// valid/ready backpressure, one beat per cycle sustained.
// Optional feature macro: VEC_POPCNT_PAD_CHECK_EN adds the sticky o_PadErr
// output flagging non-zero padding on a final beat.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_Vector     : input beat            i_Valid / o_Ready : input handshake
//   o_SubVector  : forwarded beat        o_Valid / i_Ready : output handshake
//   o_Cnt        : popcount of the most recently completed vector
//   o_CntNew     : current output beat is the last beat of a vector
//   o_VecId      : ID of the vector the current output beat belongs to
//   o_PadErr     : sticky padding error (only with VEC_POPCNT_PAD_CHECK_EN)
// -----------------------------------------------------------------------------
module vec_popcnt_stream
  import fp_accel_pkg::*;
#(
  parameter int VECTOR_WIDTH  = DEF_VECTOR_WIDTH,
  parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int GRANULE_WIDTH = DEF_GRANULE_WIDTH,
  parameter int ID_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [BUS_WIDTH-1:0]                    i_Vector,
  input  logic                                    i_Valid,
  output logic                                    o_Ready,
  output logic [BUS_WIDTH-1:0]                    o_SubVector,
  output logic                                    o_Valid,
  input  logic                                    i_Ready,
  output logic [calc_cnt_width(VECTOR_WIDTH)-1:0] o_Cnt,
  output logic                                    o_CntNew,
  output logic [ID_WIDTH-1:0]                     o_VecId
`ifdef VEC_POPCNT_PAD_CHECK_EN
  ,
  output logic                                    o_PadErr
`endif
);

  localparam int SUB_VECTOR_NO = calc_sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
  localparam int LAST_BITS     = calc_last_bits(VECTOR_WIDTH, BUS_WIDTH);
  localparam int CNT_WIDTH     = calc_cnt_width(VECTOR_WIDTH);
  localparam int BCW           = calc_beat_cnt_width(BUS_WIDTH);
  localparam int IDX_WIDTH     = calc_idx_width(SUB_VECTOR_NO);

  // Input side state
  logic [IDX_WIDTH-1:0] beat_idx_reg;
  logic [ID_WIDTH-1:0]  vec_id_reg;

  // Stage 1
  logic                 s1_valid_reg;
  logic [BUS_WIDTH-1:0] s1_data_reg;
  logic                 s1_last_reg;
  logic [ID_WIDTH-1:0]  s1_id_reg;

  // Stage 2 / outputs
  logic                 s2_valid_reg;
  logic [BUS_WIDTH-1:0] sub_vector_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] acc_reg;
  logic                 cnt_new_reg;
  logic [ID_WIDTH-1:0]  vec_id_out_reg;

  logic                 en;
  logic                 in_xfer;
  logic                 is_last;
  logic [BUS_WIDTH-1:0] last_mask;
  logic [BUS_WIDTH-1:0] masked_beat;
  logic [BCW-1:0]       beat_cnt;
  logic [CNT_WIDTH-1:0] beat_cnt_ext;

  // Whole pipeline advances together; a held output beat freezes both stages.
  assign en      = !s2_valid_reg || i_Ready;
  assign o_Ready = en;
  assign in_xfer = i_Valid && en;
  assign is_last = (beat_idx_reg == IDX_WIDTH'(SUB_VECTOR_NO - 1));

  // Bits at or above LAST_BITS are padding on the final beat; when
  // LAST_BITS == BUS_WIDTH the mask is all ones and nothing is removed.
  genvar gi;
  generate
    for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_mask
      assign last_mask[gi] = (gi < LAST_BITS) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign masked_beat = is_last ? (i_Vector & last_mask) : i_Vector;

  popcnt_granule_tree #(
    .BUS_WIDTH     (BUS_WIDTH),
    .GRANULE_WIDTH (GRANULE_WIDTH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_Vector  (masked_beat),
    .o_BeatCnt (beat_cnt)
  );

  // A masked beat never holds more than VECTOR_WIDTH ones, so the cast is safe.
  assign beat_cnt_ext = CNT_WIDTH'(beat_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx_reg   <= '0;
      vec_id_reg     <= '0;
      s1_valid_reg   <= 1'b0;
      s1_data_reg    <= '0;
      s1_last_reg    <= 1'b0;
      s1_id_reg      <= '0;
      s2_valid_reg   <= 1'b0;
      sub_vector_reg <= '0;
      cnt_reg        <= '0;
      acc_reg        <= '0;
      cnt_new_reg    <= 1'b0;
      vec_id_out_reg <= '0;
    end else begin
      if (in_xfer) begin
        if (is_last) begin
          beat_idx_reg <= '0;
          vec_id_reg   <= vec_id_reg + 1'b1;
        end else begin
          beat_idx_reg <= beat_idx_reg + 1'b1;
        end
      end

      if (en) begin
        s1_valid_reg <= i_Valid;
        if (i_Valid) begin
          s1_data_reg <= masked_beat;
          s1_last_reg <= is_last;
          s1_id_reg   <= vec_id_reg;
        end

        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          sub_vector_reg <= s1_data_reg;
          vec_id_out_reg <= s1_id_reg;
          cnt_new_reg    <= s1_last_reg;
          if (s1_last_reg) begin
            cnt_reg <= acc_reg + beat_cnt_ext;
            acc_reg <= '0;
          end else begin
            acc_reg <= acc_reg + beat_cnt_ext;
          end
        end else begin
          // Bubble: data/ID/count hold, but a bubble is never a last beat.
          cnt_new_reg <= 1'b0;
        end
      end
    end
  end

  assign o_Valid     = s2_valid_reg;
  assign o_SubVector = sub_vector_reg;
  assign o_Cnt       = cnt_reg;
  assign o_CntNew    = cnt_new_reg;
  assign o_VecId     = vec_id_out_reg;

`ifdef VEC_POPCNT_PAD_CHECK_EN
  logic pad_err_reg;

  // Sticky: checks the raw (pre-mask) final beat, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_err_reg <= 1'b0;
    end else if (in_xfer && is_last && ((i_Vector & ~last_mask) != '0)) begin
      pad_err_reg <= 1'b1;
    end
  end

  assign o_PadErr = pad_err_reg;
`endif

endmodule

// File: tb/tb_vec_popcnt_stream.sv
// -----------------------------------------------------------------------------
// tb_vec_popcnt_stream
// Self-checking bench for vec_popcnt_stream (VECTOR_WIDTH 920, BUS_WIDTH 128,
// ID_WIDTH 2 so that ID wrap is reachable). A reference model built from
// whole-vector arithmetic produces the expected output beats into a queue; a
// per-cycle loop drives stimulus, compares transferred beats, checks that
// stalled outputs stay stable and tracks the sticky padding error when
// VEC_POPCNT_PAD_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_vec_popcnt_stream;

  localparam int VW   = 920;
  localparam int BW   = 128;
  localparam int GW   = 6;
  localparam int IDW  = 2;
  localparam int SVN  = 8;
  localparam int LAST = 24;
  localparam int CNTW = 10;

  typedef logic [BW-1:0] vec_t [SVN];

  typedef struct {
    logic [BW-1:0]   data;
    logic            cnt_new;
    logic [CNTW-1:0] cnt;
    logic [IDW-1:0]  id;
  } exp_beat_t;

  typedef struct {
    logic [BW-1:0] data;
    bit            pad_bad;
  } src_beat_t;

  logic            clk;
  logic            rst;
  logic [BW-1:0]   i_Vector;
  logic            i_Valid;
  logic            o_Ready;
  logic [BW-1:0]   o_SubVector;
  logic            o_Valid;
  logic            i_Ready;
  logic [CNTW-1:0] o_Cnt;
  logic            o_CntNew;
  logic [IDW-1:0]  o_VecId;
`ifdef VEC_POPCNT_PAD_CHECK_EN
  logic            o_PadErr;
`endif

  vec_popcnt_stream #(
    .VECTOR_WIDTH  (VW),
    .BUS_WIDTH     (BW),
    .GRANULE_WIDTH (GW),
    .ID_WIDTH      (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_Vector    (i_Vector),
    .i_Valid     (i_Valid),
    .o_Ready     (o_Ready),
    .o_SubVector (o_SubVector),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Cnt       (o_Cnt),
    .o_CntNew    (o_CntNew),
    .o_VecId     (o_VecId)
`ifdef VEC_POPCNT_PAD_CHECK_EN
    ,
    .o_PadErr    (o_PadErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  src_beat_t src_q[$];
  exp_beat_t exp_q[$];

  // Reference model state
  logic [IDW-1:0]  model_id;
  logic [CNTW-1:0] last_cnt;
  bit              pad_exp;

  // Observations of completed vectors (for per-test assertions)
  logic [CNTW-1:0] new_cnt_q[$];
  logic [IDW-1:0]  new_id_q[$];
  logic [BW-1:0]   new_data_q[$];

  // Stall tracking
  bit              hold_valid;
  logic [BW-1:0]   hold_data;
  logic [CNTW-1:0] hold_cnt;
  logic            hold_new;
  logic [IDW-1:0]  hold_id;

  // Ready pattern and latency probes
  bit rdy_state = 1'b1;
  int rdy_left  = 0;
  int first_in_cyc;
  int first_out_cyc;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the masked vector is the raw vector with bits >= VW removed; the
  // vector count is the population of the masked vector.
  task automatic queue_vector(input vec_t raw, input int nbeats);
    int total;
    total = 0;
    for (int b = 0; b < nbeats; b++) begin
      logic [BW-1:0] d;
      src_beat_t s;
      exp_beat_t e;
      d = raw[b];
      s.pad_bad = 1'b0;
      if (b == SVN - 1) begin
        for (int k = LAST; k < BW; k++) begin
          if (d[k]) s.pad_bad = 1'b1;
          d[k] = 1'b0;
        end
      end
      total = total + $countones(d);
      e.cnt_new = (b == SVN - 1);
      if (e.cnt_new) last_cnt = CNTW'(total);
      e.data = d;
      e.cnt  = last_cnt;
      e.id   = model_id;
      s.data = raw[b];
      exp_q.push_back(e);
      src_q.push_back(s);
    end
    if (nbeats == SVN) model_id = model_id + 1'b1;
  endtask

  task automatic next_ready(input int mode, output bit r);
    if (mode == 0) begin
      r = 1'b1;
    end else begin
      if (rdy_left == 0) begin
        rdy_state = !rdy_state;
        rdy_left  = rdy_state ? $urandom_range(10, 1) : $urandom_range(5, 1);
      end
      rdy_left--;
      r = rdy_state;
    end
  endtask

  task automatic do_cycle(input int ready_mode, input int valid_pct);
    bit r;
    exp_beat_t e;
    src_beat_t s;
    @(negedge clk);
    cyc++;
`ifdef VEC_POPCNT_PAD_CHECK_EN
    check("pad_err", o_PadErr, pad_exp);
`endif
    if (hold_valid) begin
      check("stall_valid", o_Valid, 1'b1);
      check("stall_data", o_SubVector, hold_data);
      check("stall_cnt", o_Cnt, hold_cnt);
      check("stall_cnt_new", o_CntNew, hold_new);
      check("stall_id", o_VecId, hold_id);
    end
    if (o_Valid && first_out_cyc < 0) first_out_cyc = cyc;
    next_ready(ready_mode, r);
    i_Ready = r;
    if (src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
      i_Valid  = 1'b1;
      i_Vector = src_q[0].data;
    end else begin
      i_Valid  = 1'b0;
      i_Vector = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    if (o_Valid && i_Ready) begin
      hold_valid = 1'b0;
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", o_SubVector, e.data);
        check("out_cnt_new", o_CntNew, e.cnt_new);
        check("out_cnt", o_Cnt, e.cnt);
        check("out_id", o_VecId, e.id);
        if (o_CntNew) begin
          new_cnt_q.push_back(o_Cnt);
          new_id_q.push_back(o_VecId);
          new_data_q.push_back(o_SubVector);
        end
      end
    end else if (o_Valid) begin
      hold_valid = 1'b1;
      hold_data  = o_SubVector;
      hold_cnt   = o_Cnt;
      hold_new   = o_CntNew;
      hold_id    = o_VecId;
    end else begin
      hold_valid = 1'b0;
    end
    if (i_Valid && o_Ready) begin
      s = src_q.pop_front();
      if (s.pad_bad) pad_exp = 1'b1;
      if (first_in_cyc < 0) first_in_cyc = cyc;
    end
  endtask

  task automatic run(input int ready_mode, input int valid_pct, input bit wait_out, input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || (wait_out && exp_q.size() > 0)) && n < budget) begin
      do_cycle(ready_mode, valid_pct);
      n++;
    end
    if (n >= budget) check("drain_timeout", BW'(src_q.size() + exp_q.size()), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    i_Valid = 1'b0;
    i_Ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    new_cnt_q.delete();
    new_id_q.delete();
    new_data_q.delete();
    model_id   = '0;
    last_cnt   = '0;
    pad_exp    = 1'b0;
    hold_valid = 1'b0;
    rdy_state  = 1'b1;
    rdy_left   = 0;
    #1;
    check("rst_valid", o_Valid, 1'b0);
    check("rst_cnt", o_Cnt, '0);
    check("rst_cnt_new", o_CntNew, 1'b0);
    check("rst_sub_vector", o_SubVector, '0);
    check("rst_vec_id", o_VecId, '0);
    check("rst_ready", o_Ready, 1'b1);
`ifdef VEC_POPCNT_PAD_CHECK_EN
    check("rst_pad_err", o_PadErr, 1'b0);
`endif
  endtask

  task automatic fill(output vec_t v, input logic [BW-1:0] val);
    for (int b = 0; b < SVN; b++) v[b] = val;
  endtask

  initial begin
    vec_t v;
    logic [BW-1:0] ones_last;
    logic [IDW-1:0] exp_ids[5];

    rst      = 1'b1;
    i_Valid  = 1'b0;
    i_Ready  = 1'b0;
    i_Vector = '0;
    first_in_cyc  = -1;
    first_out_cyc = -1;
    ones_last = '0;
    for (int k = 0; k < LAST; k++) ones_last[k] = 1'b1;

    // 1) All-ones 920-bit vector, always ready
    do_reset();
    fill(v, '1);
    v[SVN-1] = ones_last;
    queue_vector(v, SVN);
    run(0, 100, 1'b1, 200);
    check("t1_num_vectors", BW'(new_cnt_q.size()), BW'(1));
    if (new_cnt_q.size() > 0) begin
      check("t1_cnt", new_cnt_q[0], BW'(920));
      check("t1_id", new_id_q[0], '0);
      check("t1_last_data", new_data_q[0], BW'(24'hFFFFFF));
    end

    // 2) Back-to-back: all zeros, then 0x1 in every beat; latency probe
    do_reset();
    first_in_cyc  = -1;
    first_out_cyc = -1;
    fill(v, '0);
    queue_vector(v, SVN);
    fill(v, BW'(1));
    queue_vector(v, SVN);
    run(0, 100, 1'b1, 200);
    check("t2_latency", BW'(first_out_cyc - first_in_cyc), BW'(2));
    check("t2_num_vectors", BW'(new_cnt_q.size()), BW'(2));
    if (new_cnt_q.size() == 2) begin
      check("t2_cnt0", new_cnt_q[0], '0);
      check("t2_id0", new_id_q[0], '0);
      check("t2_cnt1", new_cnt_q[1], BW'(8));
      check("t2_id1", new_id_q[1], BW'(1));
    end

    // 3) Random vectors (random padding too), random gaps and backpressure
    do_reset();
    for (int n = 0; n < 20; n++) begin
      for (int b = 0; b < SVN; b++) v[b] = {$urandom, $urandom, $urandom, $urandom};
      if (n % 4 == 0) fill(v, '1);
      queue_vector(v, SVN);
    end
    run(1, 70, 1'b1, 6000);
    check("t3_num_vectors", BW'(new_cnt_q.size()), BW'(20));

    // 4) Reset after beat 3 of a vector, then a clean all-ones vector
    fill(v, '1);
    queue_vector(v, 4);
    run(0, 100, 1'b0, 100);
    do_reset();
    fill(v, '1);
    v[SVN-1] = ones_last;
    queue_vector(v, SVN);
    run(0, 100, 1'b1, 200);
    check("t4_num_vectors", BW'(new_cnt_q.size()), BW'(1));
    if (new_cnt_q.size() > 0) begin
      check("t4_cnt", new_cnt_q[0], BW'(920));
      check("t4_id", new_id_q[0], '0);
    end

    // 5) Final beat carries bit 127 in the padding
    do_reset();
    fill(v, '1);
    v[SVN-1] = ones_last;
    v[SVN-1][BW-1] = 1'b1;
    queue_vector(v, SVN);
    run(1, 100, 1'b1, 400);
    for (int n = 0; n < 4; n++) do_cycle(0, 0);
    if (new_cnt_q.size() > 0) check("t5_cnt", new_cnt_q[0], BW'(920));
    else check("t5_num_vectors", BW'(0), BW'(1));
`ifdef VEC_POPCNT_PAD_CHECK_EN
    check("t5_pad_err", o_PadErr, 1'b1);
`endif

    // 6) ID wrap with a 2-bit ID: five short vectors
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int b = 0; b < SVN; b++) v[b] = {$urandom, $urandom, $urandom, $urandom};
      v[SVN-1] = v[SVN-1] & ones_last;
      queue_vector(v, SVN);
    end
    run(1, 80, 1'b1, 2000);
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check("t6_num_vectors", BW'(new_id_q.size()), BW'(5));
    for (int n = 0; n < 5 && n < new_id_q.size(); n++) begin
      check($sformatf("t6_id%0d", n), new_id_q[n], exp_ids[n]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
